gpr_operand_fetch: RTL

- Sequencer directly upstream of the 8x16 general-purpose register file (r0 hard-wired zero, single shared port, Read/Write mutually exclusive, combinational read, write on posedge).
- Serialises the decode stage's two-operand fetch requests and the writeback stage's write requests onto that single port.
- Presents latched operands A/B to the ALU with a valid pulse.
- Writeback has priority, so a fetch issued in the same cycle always sees the just-written value.

---
 rtl/gpr_operand_fetch.sv | 99 +++++++++
 1 files changed

// File: rtl/gpr_operand_fetch.sv
// Operand-fetch sequencer in front of the single-port GPR file: serialises
// writeback writes and two-operand fetches, writeback first.
module gpr_operand_fetch #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  FetchReq,
    input  logic [ADDR_WIDTH-1:0] FetchAddrA,
    input  logic [ADDR_WIDTH-1:0] FetchAddrB,
    input  logic                  FetchUseB,
    output logic                  FetchReady,
    output logic [DATA_WIDTH-1:0] OpA,
    output logic [DATA_WIDTH-1:0] OpB,
    output logic                  OpValid,
    input  logic                  WbReq,
    input  logic [ADDR_WIDTH-1:0] WbAddr,
    input  logic [DATA_WIDTH-1:0] WbData,
    output logic                  WbAck,
    output logic [ADDR_WIDTH-1:0] GprAddress,
    output logic                  GprRead,
    output logic                  GprWrite,
    output logic [DATA_WIDTH-1:0] GprDataIn,
    input  logic [DATA_WIDTH-1:0] GprDataOut
);

    typedef enum logic [2:0] {IDLE, WRITE, READ_A, READ_B, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q;
    logic                  use_b_q;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (WbReq)         state_nxt = WRITE;
                else if (FetchReq) state_nxt = READ_A;
            end
            WRITE:   state_nxt = IDLE;
            READ_A:  state_nxt = use_b_q ? READ_B : DONE;
            READ_B:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign FetchReady = (state == IDLE) && !WbReq;
    assign WbAck      = (state == WRITE);
    assign GprWrite   = (state == WRITE);
    assign GprRead    = (state == READ_A) || (state == READ_B);
    assign OpValid    = (state == DONE);

    // The bus address/data registers double as the writeback latch; loading
    // them on entry to a state keeps them stable through IDLE/DONE.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            use_b_q    <= 1'b0;
            GprAddress <= '0;
            GprDataIn  <= '0;
        end else begin
            if (state == IDLE && WbReq) begin
                GprAddress <= WbAddr;
                GprDataIn  <= WbData;
            end else if (state == IDLE && FetchReq) begin
                addr_a_q   <= FetchAddrA;
                addr_b_q   <= FetchAddrB;
                use_b_q    <= FetchUseB;
                GprAddress <= FetchAddrA;
            end else if (state == READ_A && use_b_q) begin
                GprAddress <= addr_b_q;
            end
        end
    end

    // OpB is cleared on entry to DONE so a single-operand result is clean
    // while OpValid is high.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            OpA <= '0;
            OpB <= '0;
        end else begin
            if (state == READ_A) begin
                OpA <= GprDataOut;
                if (!use_b_q) OpB <= '0;
            end
            if (state == READ_B) OpB <= GprDataOut;
        end
    end

endmodule
